// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the ALU operation encoding used by the
// issue stage and the downstream rv_alu.
package rv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ASEL_RS1,
    ASEL_ZERO,
    ASEL_PC
  } asel_t;

  typedef enum logic [1:0] {
    BSEL_RS2,
    BSEL_IMMI,
    BSEL_SHAMT,
    BSEL_IMMU
  } bsel_t;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
    logic    use_rs1;
    logic    use_rs2;
    asel_t   a_sel;
    bsel_t   b_sel;
  } dec_t;

  // alt selects SUB over ADD and SRA over SRL (instr bit 30).
  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// 2-read/1-write architectural register file; x0 reads zero, writes bypass
// to the read ports in the same cycle.
module rv_regfile
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      ra1_i,
  output logic [XLEN-1:0] rd1_o,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (ra1_i != 5'd0) begin
      rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : mem_q[ra1_i];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i != 5'd0) begin
      rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/rv_alu_issue.sv
// RV32I ALU-class decode/issue stage: scoreboarded operand read and a single
// registered slot presenting op/operands to rv_alu.
module rv_alu_issue
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = 32
) (
  input  logic            clkin,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_op,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic [XLEN-1:0] ex_pc,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_u, shamt;
  logic [XLEN-1:0] rs1_data, rs2_data;
  dec_t dec;

  assign opc   = if_instr[6:0];
  assign rd    = if_instr[11:7];
  assign f3    = if_instr[14:12];
  assign rs1   = if_instr[19:15];
  assign rs2   = if_instr[24:20];
  assign f7    = if_instr[31:25];
  assign imm_i = XLEN'($signed(if_instr[31:20]));
  assign imm_u = XLEN'($signed({if_instr[31:12], 12'b0}));
  assign shamt = XLEN'(if_instr[24:20]);

  rv_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk_i  (clkin),
    .rst_ni (rst_n),
    .ra1_i  (rs1),
    .rd1_o  (rs1_data),
    .ra2_i  (rs2),
    .rd2_o  (rs2_data),
    .we_i   (wb_we),
    .wa_i   (wb_rd),
    .wd_i   (wb_data)
  );

  always_comb begin
    dec = '{legal: 1'b0, op: ALU_ADD, use_rs1: 1'b0, use_rs2: 1'b0,
            a_sel: ASEL_ZERO, b_sel: BSEL_IMMU};
    case (opc)
      OPC_OP: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.a_sel   = ASEL_RS1;
        dec.b_sel   = BSEL_RS2;
        if (f7 == 7'h00) begin
          dec.legal = 1'b1;
          dec.op    = alu_op_from_f3(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.legal = 1'b1;
          dec.op    = alu_op_from_f3(f3, 1'b1);
        end
      end
      OPC_OPIMM: begin
        dec.use_rs1 = 1'b1;
        dec.a_sel   = ASEL_RS1;
        dec.b_sel   = BSEL_IMMI;
        dec.op      = alu_op_from_f3(f3, 1'b0);
        dec.legal   = 1'b1;
        if (f3 == 3'b001) begin
          dec.b_sel = BSEL_SHAMT;
          dec.legal = (f7 == 7'h00);
        end else if (f3 == 3'b101) begin
          dec.b_sel = BSEL_SHAMT;
          dec.op    = alu_op_from_f3(f3, f7[5]);
          dec.legal = (f7 == 7'h00) || (f7 == 7'h20);
        end
      end
      OPC_LUI: begin
        dec.legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec.legal = 1'b1;
        dec.a_sel = ASEL_PC;
      end
      default: ;
    endcase
  end

  logic [NREG-1:0] sb_q, sb_d;
  logic            busy1, busy2, hazard, free;
  logic            accept, acc_legal, acc_illegal;

  logic            ex_valid_q, ex_valid_d;
  alu_op_t         ex_op_q, ex_op_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_pc_q, ex_pc_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_we_q, ex_we_d;
  logic            illegal_q, illegal_d;

  // Illegal encodings are dropped, so their source fields never stall.
  assign busy1       = sb_q[rs1] && !(wb_we && (wb_rd == rs1));
  assign busy2       = sb_q[rs2] && !(wb_we && (wb_rd == rs2));
  assign hazard      = dec.legal && ((busy1 && dec.use_rs1) || (busy2 && dec.use_rs2));
  assign free        = !ex_valid_q || ex_ready;
  assign if_ready    = free && !hazard;
  assign accept      = if_valid && if_ready;
  assign acc_legal   = accept && dec.legal;
  assign acc_illegal = accept && !dec.legal;

  always_comb begin
    sb_d = sb_q;
    if (wb_we) begin
      sb_d[wb_rd] = 1'b0;
    end
    if (acc_legal && (rd != 5'd0)) begin
      sb_d[rd] = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q && !ex_ready;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_pc_d    = ex_pc_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    illegal_d  = acc_illegal;
    if (acc_legal) begin
      ex_valid_d = 1'b1;
      ex_op_d    = dec.op;
      ex_pc_d    = if_pc;
      ex_rd_d    = rd;
      ex_we_d    = (rd != 5'd0);
      case (dec.a_sel)
        ASEL_RS1: ex_a_d = rs1_data;
        ASEL_PC:  ex_a_d = if_pc;
        default:  ex_a_d = '0;
      endcase
      case (dec.b_sel)
        BSEL_RS2:   ex_b_d = rs2_data;
        BSEL_IMMI:  ex_b_d = imm_i;
        BSEL_SHAMT: ex_b_d = shamt;
        default:    ex_b_d = imm_u;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sb_q       <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= ALU_ADD;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_pc_q    <= '0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_pc_q    <= ex_pc_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_pc    = ex_pc_q;
  assign ex_rd    = ex_rd_q;
  assign ex_we    = ex_we_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed bench for rv_alu_issue: hand-encoded RV32I vectors with
// hand-computed expected issue outputs.
module tb_rv_alu_issue;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_op;
  logic [31:0] ex_a, ex_b, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_we, illegal;

  int checks = 0;
  int failures = 0;

  rv_alu_issue #(.XLEN(32), .NREG(32)) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_op    (ex_op),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .ex_rd    (ex_rd),
    .ex_we    (ex_we),
    .ex_pc    (ex_pc),
    .illegal  (illegal)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
    chk({tag, ".op"},    32'(ex_op),    32'(op));
    chk({tag, ".a"},     ex_a,          a);
    chk({tag, ".b"},     ex_b,          b);
    chk({tag, ".rd"},    32'(ex_rd),    32'(rd));
    chk({tag, ".we"},    32'(ex_we),    32'(rd != 5'd0));
    chk({tag, ".pc"},    ex_pc,         pc);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".valid"},   32'(ex_valid), 32'd0);
    chk({tag, ".op"},      32'(ex_op),    32'd0);
    chk({tag, ".a"},       ex_a,          32'd0);
    chk({tag, ".b"},       ex_b,          32'd0);
    chk({tag, ".pc"},      ex_pc,         32'd0);
    chk({tag, ".rd"},      32'(ex_rd),    32'd0);
    chk({tag, ".we"},      32'(ex_we),    32'd0);
    chk({tag, ".illegal"}, 32'(illegal),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b0;
    #12;
    chk_reset_outs("reset");
    @(negedge clkin);
    rst_n = 1'b1;
    tick();

    // ADDI x1,x0,5
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h0;
    #1 chk("addi.if_ready", 32'(if_ready), 32'd1);
    tick();
    chk_ex("addi", 4'd0, 32'd0, 32'd5, 5'd1, 32'h0);

    // ADD x2,x1,x1 stalls on busy x1
    if_instr = 32'h0010_8133; if_pc = 32'h4;
    #1 chk("add.stall0", 32'(if_ready), 32'd0);
    tick();
    chk("add.drain_valid", 32'(ex_valid), 32'd0);
    chk("add.stall1", 32'(if_ready), 32'd0);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1 chk("add.wb_release", 32'(if_ready), 32'd1);
    tick();
    wb_we = 1'b0;
    chk_ex("add", 4'd0, 32'd5, 32'd5, 5'd2, 32'h4);

    // SUB x3,x1,x2 with x2 written back in the accept cycle
    if_instr = 32'h4020_81B3; if_pc = 32'h8;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd10;
    #1 chk("sub.if_ready", 32'(if_ready), 32'd1);
    tick();
    wb_we = 1'b0;
    chk_ex("sub", 4'd1, 32'd5, 32'd10, 5'd3, 32'h8);

    // funct7=0x20 with funct3=001 is illegal
    if_instr = 32'h4000_10B3; if_pc = 32'hC;
    #1 chk("ill.if_ready", 32'(if_ready), 32'd1);
    tick();
    chk("ill.pulse", 32'(illegal), 32'd1);
    chk("ill.valid", 32'(ex_valid), 32'd0);

    // ADD x4,x1,x1: x1 must not have been marked busy by the dropped op
    if_instr = 32'h0010_8233; if_pc = 32'h10;
    #1 chk("add4.if_ready", 32'(if_ready), 32'd1);
    tick();
    chk("ill.pulse_end", 32'(illegal), 32'd0);
    chk_ex("add4", 4'd0, 32'd5, 32'd5, 5'd4, 32'h10);

    // LUI x5,0x12345 then AUIPC x6,1 at pc 0x100
    if_instr = 32'h1234_52B7; if_pc = 32'h14;
    tick();
    chk_ex("lui", 4'd0, 32'd0, 32'h1234_5000, 5'd5, 32'h14);
    if_instr = 32'h0000_1317; if_pc = 32'h100;
    tick();
    chk_ex("auipc", 4'd0, 32'h100, 32'h1000, 5'd6, 32'h100);

    // Backpressure: AUIPC result held while ex_ready=0
    ex_ready = 1'b0; if_instr = 32'h0030_0393; if_pc = 32'h104;
    #1 chk("bp.if_ready", 32'(if_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ex("bp.hold", 4'd0, 32'h100, 32'h1000, 5'd6, 32'h100);
      chk("bp.stall", 32'(if_ready), 32'd0);
    end
    ex_ready = 1'b1;
    #1 chk("bp.release", 32'(if_ready), 32'd1);
    tick();
    chk_ex("addi7", 4'd0, 32'd0, 32'd3, 5'd7, 32'h104);

    // ADD x8,x7,x7 stalls; async reset lands mid-stall
    ex_ready = 1'b0; if_instr = 32'h0073_8433; if_pc = 32'h108;
    #1 chk("rst.stall", 32'(if_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("midreset");
    if_valid = 1'b0; ex_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();

    // After reset the scoreboard is clear and x1 reads 0
    if_valid = 1'b1; if_instr = 32'h0010_8133; if_pc = 32'h200;
    #1 chk("post.if_ready", 32'(if_ready), 32'd1);
    tick();
    chk_ex("post.add", 4'd0, 32'd0, 32'd0, 5'd2, 32'h200);

    // SRAI x9,x1,3: funct7=0x20 shift, b is the shamt
    if_instr = 32'h4030_D493; if_pc = 32'h204;
    tick();
    chk_ex("srai", 4'd7, 32'd0, 32'd3, 5'd9, 32'h204);

    // All-zero word: low bits not 11, dropped
    if_instr = 32'h0000_0000; if_pc = 32'h208;
    tick();
    chk("zero.illegal", 32'(illegal), 32'd1);
    chk("zero.valid", 32'(ex_valid), 32'd0);
    if_valid = 1'b0;
    tick();
    chk("zero.pulse_end", 32'(illegal), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
